// File: rtl/snn_batch_checker.sv
// Batch sequencer: runs snn_core over NUM_SAMPLES stored images back-to-back,
// scores each result against a label RAM and keeps pass/fail/timeout tallies.
module snn_batch_checker #(
  parameter int NUM_SAMPLES = 16,
  parameter int IDX_W       = 4,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               abort,
  output logic               core_start,
  input  logic               core_done,
  input  logic [DIGIT_W-1:0] core_digit,
  output logic [IDX_W-1:0]   sample_sel,
  output logic [IDX_W-1:0]   label_addr,
  input  logic [DIGIT_W-1:0] label_q,
  output logic               busy,
  output logic               batch_done,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic [IDX_W-1:0]   last_fail_idx,
  output logic [DIGIT_W-1:0] last_fail_digit
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LABEL, S_START, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] exp_digit;
  logic [DIGIT_W-1:0] got_digit;
  logic               timed_out;
  logic [TMR_W-1:0]   tmr;
  logic               done_q;
  logic               done_rise;
  logic               tmr_expired;
  logic               sample_ok;

  assign done_rise   = core_done & ~done_q;
  assign tmr_expired = (tmr == TMR_LAST);
  assign sample_ok   = ~timed_out & (got_digit == exp_digit);
  assign sample_sel  = idx;
  assign label_addr  = idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every register is written with <= so all flops sample the same
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (run) state_nx = S_LABEL;
      S_LABEL: state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (done_rise || tmr_expired) state_nx = S_CHECK;
      S_CHECK: state_nx = (idx == IDX_LAST) ? S_DONE : S_LABEL;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Control outputs are flops loaded from the next state, so they track the
  // state register exactly without any input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_start <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      core_start <= (state_nx == S_START);
      busy       <= (state_nx != S_IDLE);
      batch_done <= (state_nx == S_DONE);
      done_q     <= core_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      exp_digit       <= '0;
      got_digit       <= '0;
      timed_out       <= 1'b0;
      tmr             <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      timeout_cnt     <= '0;
      last_fail_idx   <= '0;
      last_fail_digit <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (run) begin
            idx             <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            timeout_cnt     <= '0;
            last_fail_idx   <= '0;
            last_fail_digit <= '0;
          end
        end
        S_START: begin
          exp_digit <= label_q;
          tmr       <= '0;
        end
        S_WAIT: begin
          tmr <= tmr + TMR_W'(1);
          // A done edge coinciding with expiry wins over the timeout.
          if (done_rise) begin
            got_digit <= core_digit;
            timed_out <= 1'b0;
          end else if (tmr_expired) begin
            got_digit <= '0;
            timed_out <= 1'b1;
          end
        end
        S_CHECK: begin
          if (sample_ok) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt        <= sat_inc(fail_cnt);
            last_fail_idx   <= idx;
            last_fail_digit <= got_digit;
          end
          if (timed_out) timeout_cnt <= sat_inc(timeout_cnt);
          if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
